// File: rtl/eth_pkg.sv
// Shared types and header geometry for the Ethernet address firewall.
package eth_pkg;

  typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD, DROP} fw_state_t;

  localparam int DEST_DIBITS = 24;
  localparam int SRC_DIBITS  = 24;
  localparam int TYPE_DIBITS = 8;
  localparam int HDR_DIBITS  = 56;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Dibit k of a MAC as it appears on the wire: byte k/4 (first byte = [47:40]), LSB-first within the byte.
  function automatic logic [1:0] mac_dibit(input logic [47:0] mac, input logic [5:0] k);
    logic [47:0] aligned;
    logic [7:0]  octet;
    aligned = mac << {k[4:2], 3'b000};
    octet   = aligned[47:40];
    return octet[{k[1:0], 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/eth_firewall_if.sv
// Dibit stream in/out plus length/type publication of the firewall; drop_count_out only with FIREWALL_STATS_EN.
interface eth_firewall_if;
  logic        axiiv_in;
  logic [1:0]  axiid_in;
  logic        axiov_out;
  logic [1:0]  axiod_out;
  logic [15:0] len_out;
  logic        len_valid_out;
`ifdef FIREWALL_STATS_EN
  logic [15:0] drop_count_out;
`endif

`ifdef FIREWALL_STATS_EN
  modport slave  (input axiiv_in, axiid_in,
                  output axiov_out, axiod_out, len_out, len_valid_out, drop_count_out);
  modport master (output axiiv_in, axiid_in,
                  input axiov_out, axiod_out, len_out, len_valid_out, drop_count_out);
`else
  modport slave  (input axiiv_in, axiid_in,
                  output axiov_out, axiod_out, len_out, len_valid_out);
  modport master (output axiiv_in, axiid_in,
                  input axiov_out, axiod_out, len_out, len_valid_out);
`endif
endinterface

// File: rtl/eth_firewall.sv
// On-the-fly Ethernet header parser: drops frames not addressed to MY_MAC (or broadcast), forwards payload+FCS.
// Optional drop statistics counter enabled by defining FIREWALL_STATS_EN.
module eth_firewall
  import eth_pkg::*;
#(
    parameter logic [47:0] MY_MAC           = 48'h69_69_5A_06_54_91,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic           clk_in,
    input  logic           rstn_in,
    eth_firewall_if.slave  bus
);

    localparam logic [5:0] K_DEST_LAST = 6'(DEST_DIBITS - 1);
    localparam logic [5:0] K_SRC_LAST  = 6'(DEST_DIBITS + SRC_DIBITS - 1);
    localparam logic [5:0] K_TYPE_LAST = 6'(HDR_DIBITS - 1);
    localparam logic [5:0] K_SAT       = 6'(HDR_DIBITS);

    fw_state_t   state, state_next;
    logic [5:0]  k;
    logic        own_mis, bc_mis;
    logic        resync;
    logic [15:0] len_acc, len_acc_next;
    logic [15:0] len_q;
    logic        len_valid_q;
    logic        ov_q;
    logic [1:0]  od_q;
    logic        own_mis_now, bc_mis_now, addr_ok;
    logic        frame_start;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        own_mis_now  = 1'b0;
        bc_mis_now   = 1'b0;
        addr_ok      = 1'b0;
        len_acc_next = len_acc;
        frame_start  = (state == IDLE) && bus.axiiv_in && !resync;

        // Flags from a previous frame are stale in IDLE, so only DEST accumulates them.
        own_mis_now = (own_mis && state == DEST) || (bus.axiid_in != mac_dibit(MY_MAC, k));
        bc_mis_now  = (bc_mis  && state == DEST) || (bus.axiid_in != mac_dibit(BROADCAST_MAC, k));
        addr_ok     = !own_mis_now || (ACCEPT_BROADCAST && !bc_mis_now);

        // Type bytes arrive LSB-first; byte0 lands in [15:8], byte1 in [7:0].
        len_acc_next[{~k[2], k[1:0], 1'b0} +: 2] = bus.axiid_in;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = DEST;
            DEST:    if (!bus.axiiv_in) state_next = IDLE;
                     else if (k == K_DEST_LAST) state_next = addr_ok ? SRC : DROP;
            SRC:     if (!bus.axiiv_in) state_next = IDLE;
                     else if (k == K_SRC_LAST) state_next = TYPE;
            TYPE:    if (!bus.axiiv_in) state_next = IDLE;
                     else if (k == K_TYPE_LAST) state_next = PAYLOAD;
            PAYLOAD: if (!bus.axiiv_in) state_next = IDLE;
            DROP:    if (!bus.axiiv_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) state <= IDLE;
        // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
        else          state <= state_next;
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            k           <= '0;
            own_mis     <= 1'b0;
            bc_mis      <= 1'b0;
            resync      <= 1'b1;
            len_acc     <= '0;
            len_q       <= '0;
            len_valid_q <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= '0;
        end else begin
            len_valid_q <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= '0;

            if (state == PAYLOAD) begin
                ov_q <= bus.axiiv_in;
                od_q <= bus.axiid_in;
            end

            // After a reset we may be mid-frame; wait for a gap before parsing a header.
            if (!bus.axiiv_in)   resync <= 1'b0;

            if (!bus.axiiv_in)        k <= '0;
            else if (state == IDLE)   k <= frame_start ? 6'd1 : 6'd0;
            else if (k != K_SAT)      k <= k + 6'd1;

            if (frame_start || (state == DEST && bus.axiiv_in)) begin
                own_mis <= own_mis_now;
                bc_mis  <= bc_mis_now;
            end

            if (state == TYPE && bus.axiiv_in) begin
                len_acc <= len_acc_next;
                if (k == K_TYPE_LAST) begin
                    len_q       <= len_acc_next;
                    len_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef FIREWALL_STATS_EN
    logic [16-1:0] drop_count;

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) drop_count <= '0;
        else if (state == DEST && state_next == DROP && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

    assign bus.drop_count_out = drop_count;
`endif

    assign bus.axiov_out     = ov_q;
    assign bus.axiod_out     = od_q;
    assign bus.len_out       = len_q;
    assign bus.len_valid_out = len_valid_q;

endmodule

// File: tb/tb_eth_firewall.sv
// Directed self-checking bench for eth_firewall; drop counter checks run when FIREWALL_STATS_EN is defined.
module tb_eth_firewall;
  import eth_pkg::*;

  localparam logic [47:0] MY_MAC  = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] FLIPPED = 48'h69_69_5A_06_54_11;  // bit 7 of byte 5 (dibit k=23) flipped

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] fb [80];
  int   fn;
  int   last_out_cnt;

  eth_firewall_if bus ();
  eth_firewall_if bus_nb ();

  eth_firewall #(.MY_MAC(MY_MAC), .ACCEPT_BROADCAST(1'b1)) dut (
    .clk_in (clk), .rstn_in(rstn), .bus(bus));
  eth_firewall #(.MY_MAC(MY_MAC), .ACCEPT_BROADCAST(1'b0)) dut_nb (
    .clk_in (clk), .rstn_in(rstn), .bus(bus_nb));

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    bus.axiiv_in    = v;
    bus.axiid_in    = d;
    bus_nb.axiiv_in = v;
    bus_nb.axiid_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 2'b00);
      @(negedge clk);
    end
  endtask

  task automatic build_frame(input logic [47:0] dest, input logic [15:0] typ, input int plen);
    logic [47:0] src;
    logic [31:0] fcs;
    src = 48'hFD_75_30_08_C2_96;
    fcs = 32'hDE_AD_BE_EF;
    for (int b = 0; b < 6; b++) fb[b]     = dest[47-8*b -: 8];
    for (int b = 0; b < 6; b++) fb[6 + b] = src[47-8*b -: 8];
    fb[12] = typ[15:8];
    fb[13] = typ[7:0];
    for (int b = 0; b < plen; b++) fb[14 + b] = 8'((b * 37 + 11) ^ (b << 3));
    for (int b = 0; b < 4; b++) fb[14 + plen + b] = fcs[31-8*b -: 8];
    fn = 14 + plen + 4;
  endtask

  function automatic logic [1:0] dibit(input int i);
    logic [7:0] b;
    b = fb[i / 4];
    return b[2 * (i % 4) +: 2];
  endfunction

  // Sends the first n dibits of fb, then one idle cycle. Every cycle the observed output is compared
  // with the dibit driven one cycle earlier (or 0 where nothing should be forwarded).
  task automatic send_frame(input string tag, input bit sel, input int n, input bit acc,
                            input logic [15:0] exp_len, input int rst_at);
    int lat_err = 0;
    int out_cnt = 0;
    int exp_cnt = 0;
    int pulses = 0;
    int exp_pulses;
    logic [15:0] plen = '0;
    logic pv = 1'b0;
    logic [1:0] pd = 2'b00;
    logic ov, lv;
    logic [1:0] od;
    logic [15:0] lo;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) rstn = 1'b0;
      if (rst_at >= 0 && i == rst_at + 2) rstn = 1'b1;
      drive(i < n, (i < n) ? dibit(i) : 2'b00);
      @(negedge clk);
      ov = sel ? bus_nb.axiov_out     : bus.axiov_out;
      od = sel ? bus_nb.axiod_out     : bus.axiod_out;
      lv = sel ? bus_nb.len_valid_out : bus.len_valid_out;
      lo = sel ? bus_nb.len_out       : bus.len_out;
      if (ov !== pv || (pv && od !== pd)) lat_err++;
      if (ov) out_cnt++;
      if (lv) begin pulses++; plen = lo; end
      pv = acc && (i < n) && (i >= HDR_DIBITS) && !(rst_at >= 0 && i >= rst_at - 1);
      pd = (i < n) ? dibit(i) : 2'b00;
      if (pv) exp_cnt++;
    end
    exp_pulses = (acc && n >= HDR_DIBITS) ? 1 : 0;
    check({tag, " stream"}, 32'(lat_err), 32'd0);
    check({tag, " count"}, 32'(out_cnt), 32'(exp_cnt));
    check({tag, " len_pulses"}, 32'(pulses), 32'(exp_pulses));
    if (exp_pulses == 1) check({tag, " len"}, 32'(plen), 32'(exp_len));
    last_out_cnt = out_cnt;
  endtask

  initial begin
    drive(1'b0, 2'b00);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset axiov", 32'(bus.axiov_out), 32'd0);
    check("reset axiod", 32'(bus.axiod_out), 32'd0);
    check("reset len", 32'(bus.len_out), 32'd0);
    check("reset len_valid", 32'(bus.len_valid_out), 32'd0);
`ifdef FIREWALL_STATS_EN
    check("reset drop_count", 32'(bus.drop_count_out), 32'd0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);

    // 1: broadcast, type 0x0015, 21-byte payload + FCS = 100 dibits forwarded
    build_frame(BROADCAST_MAC, 16'h0015, 21);
    send_frame("t1 bcast", 1'b0, 4 * fn, 1'b1, 16'h0015, -1);
    check("t1 dibits", 32'(last_out_cnt), 32'd100);

    // 2: own address accepted; one flipped bit at k=23 dropped
    build_frame(MY_MAC, 16'h86DD, 21);
    send_frame("t2 own", 1'b0, 4 * fn, 1'b1, 16'h86DD, -1);
    check("t2 len_out", 32'(bus.len_out), 32'h86DD);
    build_frame(FLIPPED, 16'h0800, 21);
    send_frame("t2 flip", 1'b0, 4 * fn, 1'b0, 16'h0000, -1);
    check("t2 len_kept", 32'(bus.len_out), 32'h86DD);
`ifdef FIREWALL_STATS_EN
    check("t2 drop_count", 32'(bus.drop_count_out), 32'd1);
`endif

    // 3: broadcast rejected when ACCEPT_BROADCAST=0; runt ending at k=30
    build_frame(BROADCAST_MAC, 16'h0806, 10);
    send_frame("t3 nobcast", 1'b1, 4 * fn, 1'b0, 16'h0000, -1);
    check("t3 bcast_len", 32'(bus.len_out), 32'h0806);
    build_frame(MY_MAC, 16'h1234, 10);
    send_frame("t3 runt", 1'b0, 30, 1'b1, 16'h0000, -1);
    idle(1);
    check("t3 runt_state", 32'(dut.state), 32'(IDLE));
    check("t3 runt_len_kept", 32'(bus.len_out), 32'h0806);

    // 4: back-to-back frames with a single idle cycle between them
    build_frame(MY_MAC, 16'h0015, 21);
    send_frame("t4 first", 1'b0, 4 * fn, 1'b1, 16'h0015, -1);
    build_frame(BROADCAST_MAC, 16'h0800, 30);
    send_frame("t4 second", 1'b0, 4 * fn, 1'b1, 16'h0800, -1);
    check("t4 second_dibits", 32'(last_out_cnt), 32'd136);

    // 5: reset for 2 cycles at payload dibit 10 (k=66); the tail is ignored, next frame accepted
    build_frame(MY_MAC, 16'h0015, 21);
    send_frame("t5 reset", 1'b0, 4 * fn, 1'b1, 16'h0015, 66);
    check("t5 len_cleared", 32'(bus.len_out), 32'd0);
    check("t5 state", 32'(dut.state), 32'(IDLE));
    build_frame(MY_MAC, 16'h0042, 12);
    send_frame("t5 next", 1'b0, 4 * fn, 1'b1, 16'h0042, -1);
    check("t5 next_len_out", 32'(bus.len_out), 32'h0042);

`ifdef FIREWALL_STATS_EN
    // 6: counter preloaded near the top, then mismatched frames cut right after the dest field
    check("t6 drop_after_reset", 32'(bus.drop_count_out), 32'd0);
    force dut.drop_count = 16'hFFFC;
    @(posedge clk); #1;
    release dut.drop_count;
    build_frame(FLIPPED, 16'h0000, 4);
    for (int f = 0; f < 2; f++) send_frame("t6 drop", 1'b0, 24, 1'b0, 16'h0000, -1);
    check("t6 drop_count_mid", 32'(bus.drop_count_out), 32'h0000FFFE);
    for (int f = 0; f < 3; f++) send_frame("t6 drop", 1'b0, 24, 1'b0, 16'h0000, -1);
    check("t6 drop_count_sat", 32'(bus.drop_count_out), 32'h0000FFFF);
    build_frame(FLIPPED, 16'h0000, 4);
    send_frame("t6 runt22", 1'b0, 22, 1'b0, 16'h0000, -1);
    check("t6 runt_not_counted", 32'(bus.drop_count_out), 32'h0000FFFF);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
